// File: rtl/dma_axi_w_if.sv
// -----------------------------------------------------------------------------
// dma_axi_w_if
// Bundles the two buses seen by the DMA AXI write master:
//   - the aligned beat stream coming from the write-data aligner
//     (dma_w_valid/addr/wdata/wstrb/len in, dma_w_ready out)
//   - the AXI4 AW, W and B channels going to the system interconnect
// Modports:
//   master : the burst master's view (drives AW/W, bready, dma_w_ready)
//   slave  : the environment's view (aligner plus interconnect side)
// -----------------------------------------------------------------------------
interface dma_axi_w_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8
);
    // Beat stream from the aligner
    logic                   dma_w_valid;
    logic [ADDR_W-1:0]      dma_w_addr;
    logic [DATA_W-1:0]      dma_w_wdata;
    logic [DATA_W/8-1:0]    dma_w_wstrb;
    logic [AXI_LEN_W-1:0]   dma_w_len;
    logic                   dma_w_ready;

    // AXI4 write address channel
    logic [ADDR_W-1:0]      m_axi_awaddr;
    logic [AXI_LEN_W-1:0]   m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awvalid;
    logic                   m_axi_awready;

    // AXI4 write data channel
    logic [DATA_W-1:0]      m_axi_wdata;
    logic [DATA_W/8-1:0]    m_axi_wstrb;
    logic                   m_axi_wlast;
    logic                   m_axi_wvalid;
    logic                   m_axi_wready;

    // AXI4 write response channel
    logic [1:0]             m_axi_bresp;
    logic                   m_axi_bvalid;
    logic                   m_axi_bready;

    modport master (
        input  dma_w_valid, dma_w_addr, dma_w_wdata, dma_w_wstrb, dma_w_len,
        output dma_w_ready,
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output dma_w_valid, dma_w_addr, dma_w_wdata, dma_w_wstrb, dma_w_len,
        input  dma_w_ready,
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/dma_axi_w.sv
// -----------------------------------------------------------------------------
// dma_axi_w
// AXI4 write burst master for the DMA write path. Each burst announced by the
// aligner becomes one AW transaction, the matching W beats (wlast on the final
// one) and a wait for the B response. Only one burst is in flight at a time.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear of the sticky error flag
//   bus    : dma_axi_w_if.master (aligner beat stream + AXI AW/W/B channels)
//   busy   : high whenever the engine is not idle
//   error  : sticky, set by any non-OKAY write response
// -----------------------------------------------------------------------------
module dma_axi_w #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    dma_axi_w_if.master       bus,
    output logic              busy,
    output logic              error
);

    localparam int STRB_W = DATA_W / 8;

    // Every beat is a full data word, so the size field is fixed
    localparam logic [2:0] AXI_SIZE  = 3'($clog2(STRB_W));
    localparam logic [1:0] AXI_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]           state_q,    state_d;
    logic [ADDR_W-1:0]    awaddr_q,   awaddr_d;
    logic [AXI_LEN_W-1:0] awlen_q,    awlen_d;
    logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                 error_q,    error_d;

    logic in_data;
    logic in_resp;
    logic w_hs;
    logic b_hs;
    logic last_beat;

    assign in_data   = (state_q == S_DATA);
    assign in_resp   = (state_q == S_RESP);
    assign last_beat = (beat_cnt_q == '0);

    // W channel is a straight pass-through of the aligner stream, gated to
    // the DATA state so no beat can leave before the AW handshake.
    assign bus.m_axi_wvalid  = bus.dma_w_valid & in_data;
    assign bus.m_axi_wdata   = bus.dma_w_wdata;
    assign bus.m_axi_wstrb   = bus.dma_w_wstrb;
    assign bus.m_axi_wlast   = in_data & last_beat;
    assign bus.dma_w_ready   = bus.m_axi_wready & in_data;

    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = awlen_q;
    assign bus.m_axi_awsize  = AXI_SIZE;
    assign bus.m_axi_awburst = AXI_INCR;
    assign bus.m_axi_awvalid = (state_q == S_ADDR);
    assign bus.m_axi_bready  = in_resp;

    assign w_hs = bus.m_axi_wvalid & bus.m_axi_wready;
    assign b_hs = in_resp & bus.m_axi_bvalid;

    assign busy  = (state_q != S_IDLE);
    assign error = error_q;

    // Burst sequencing. The address and length are captured once per burst in
    // IDLE; the beat counter then walks down to zero and the beat that
    // handshakes at zero closes the burst, so the counter can never wrap.
    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dma_w_valid) begin
                    awaddr_d   = bus.dma_w_addr;
                    awlen_d    = bus.dma_w_len;
                    beat_cnt_d = bus.dma_w_len;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.m_axi_awready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (last_beat) begin
                        state_d = S_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (bus.m_axi_bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky error: a failing response in the same cycle as clear must not be
    // lost, so the set term has priority.
    always_comb begin
        error_d = error_q;
        if (b_hs && (bus.m_axi_bresp != RESP_OKAY)) begin
            error_d = 1'b1;
        end else if (clear) begin
            error_d = 1'b0;
        end
    end

    // State registers. Reset abandons any in-flight AXI transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            beat_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            beat_cnt_q <= beat_cnt_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_dma_axi_w.sv
// -----------------------------------------------------------------------------
// tb_dma_axi_w
// Scoreboard bench for dma_axi_w. Stimulus tasks push the expected AW and W
// transactions into queues; an independent monitor pops and compares them on
// every handshake the DUT presents. A responder process models the AXI slave.
// -----------------------------------------------------------------------------
module tb_dma_axi_w;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int AXI_LEN_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy;
    logic error;

    dma_axi_w_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W)) bus ();

    dma_axi_w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus),
        .busy  (busy),
        .error (error)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] expAwAddr[$];
    logic [7:0]  expAwLen[$];
    logic [31:0] expWData[$];
    logic [3:0]  expWStrb[$];
    logic        expWLast[$];

    int wHsCount     = 0;
    int wLastCount   = 0;
    int awStallCount = 0;

    int         awDelay    = 0;
    int         wreadyMode = 0;
    logic [1:0] nextBresp  = 2'b00;
    logic       abortReq   = 1'b0;
    int         awWait     = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: event did not occur in time / unexpected", name);
    endtask

    function automatic logic [31:0] beatData(input logic [31:0] base, input int i);
        return {base[15:0], 16'(i)};
    endfunction

    function automatic logic [3:0] beatStrb(input int i);
        return (i % 3 == 0) ? 4'hF : ((i % 3 == 1) ? 4'h3 : 4'hC);
    endfunction

    task automatic expectAw(input logic [31:0] addr, input logic [7:0] len);
        expAwAddr.push_back(addr);
        expAwLen.push_back(len);
    endtask

    // Aligner model: presents n beats from base, holding valid until ready.
    // Bursts are cut at 256 beats, so wlast falls on every 256th beat and on
    // the final beat of the stream.
    task automatic applyStimulus(input logic [31:0] base, input int n, input bit gaps);
        int  cycles;
        bit  acc;
        int  rem;
        for (int i = 0; i < n; i++) begin
            expWData.push_back(beatData(base, i));
            expWStrb.push_back(beatStrb(i));
            expWLast.push_back(((i % 256) == 255) || (i == n - 1));
        end
        for (int i = 0; i < n && !abortReq; i++) begin
            rem = n - i;
            bus.dma_w_valid = 1'b1;
            bus.dma_w_addr  = base + 32'(4 * i);
            bus.dma_w_wdata = beatData(base, i);
            bus.dma_w_wstrb = beatStrb(i);
            bus.dma_w_len   = (rem > 256) ? 8'd255 : 8'(rem - 1);
            cycles = 0;
            acc    = 1'b0;
            while (!acc && !abortReq && cycles < 400) begin
                @(negedge clk);
                acc = bus.dma_w_ready;
                @(posedge clk);
                #1;
                cycles++;
            end
            if (!acc && !abortReq) failNow("beat_accept_timeout");
            if (gaps && acc && (i % 2 == 0) && !abortReq) begin
                bus.dma_w_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.dma_w_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 2000);
        if (busy) failNow(name);
    endtask

    // AXI slave model: awready after a programmable number of stall cycles,
    // wready always high or toggling, bvalid raised in the first RESP cycle.
    always @(posedge clk) begin
        #1;
        if (bus.m_axi_awvalid) begin
            bus.m_axi_awready = (awWait >= awDelay);
            awWait++;
        end else begin
            bus.m_axi_awready = 1'b0;
            awWait = 0;
        end
        if (wreadyMode == 1) bus.m_axi_wready = ~bus.m_axi_wready;
        else                 bus.m_axi_wready = 1'b1;
        bus.m_axi_bvalid = bus.m_axi_bready;
        bus.m_axi_bresp  = nextBresp;
    end

    // Monitor: compares every AW and W handshake with the scoreboard queues,
    // checks AW stability while stalled, and that no beat leaks outside DATA.
    always @(negedge clk) begin
        if (!rst_n) begin
            expAwAddr.delete();
            expAwLen.delete();
            expWData.delete();
            expWStrb.delete();
            expWLast.delete();
        end else begin
            if (bus.m_axi_awvalid) begin
                checkOutput("aw_phase_wvalid", bus.m_axi_wvalid, 0);
                checkOutput("aw_phase_dma_ready", bus.dma_w_ready, 0);
                if (expAwAddr.size() == 0) begin
                    failNow("aw_unexpected");
                end else begin
                    checkOutput("awaddr", bus.m_axi_awaddr, expAwAddr[0]);
                    checkOutput("awlen", bus.m_axi_awlen, expAwLen[0]);
                    checkOutput("awsize", bus.m_axi_awsize, 2);
                    checkOutput("awburst", bus.m_axi_awburst, 1);
                    if (bus.m_axi_awready) begin
                        void'(expAwAddr.pop_front());
                        void'(expAwLen.pop_front());
                    end else begin
                        awStallCount++;
                    end
                end
            end
            if (bus.m_axi_wvalid) begin
                checkOutput("dma_w_ready_eq_wready", bus.dma_w_ready, bus.m_axi_wready);
                if (bus.m_axi_wready) begin
                    wHsCount++;
                    if (bus.m_axi_wlast) wLastCount++;
                    if (expWData.size() == 0) begin
                        failNow("w_unexpected");
                    end else begin
                        checkOutput("wdata", bus.m_axi_wdata, expWData.pop_front());
                        checkOutput("wstrb", bus.m_axi_wstrb, expWStrb.pop_front());
                        checkOutput("wlast", bus.m_axi_wlast, expWLast.pop_front());
                    end
                end
            end
            if (bus.m_axi_bready) begin
                checkOutput("resp_phase_wvalid", bus.m_axi_wvalid, 0);
                checkOutput("resp_phase_dma_ready", bus.dma_w_ready, 0);
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        int h0;
        int l0;
        int s0;
        int c;

        bus.dma_w_valid   = 1'b0;
        bus.dma_w_addr    = '0;
        bus.dma_w_wdata   = '0;
        bus.dma_w_wstrb   = '0;
        bus.dma_w_len     = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;

        // Reset values
        #2;
        checkOutput("rst_awvalid", bus.m_axi_awvalid, 0);
        checkOutput("rst_wvalid", bus.m_axi_wvalid, 0);
        checkOutput("rst_wlast", bus.m_axi_wlast, 0);
        checkOutput("rst_bready", bus.m_axi_bready, 0);
        checkOutput("rst_dma_ready", bus.dma_w_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_awaddr", bus.m_axi_awaddr, 0);
        checkOutput("rst_awlen", bus.m_axi_awlen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat with one-cycle AW latency
        $display("[TB] single beat");
        expectAw(32'h100, 8'd0);
        h0 = wHsCount;
        l0 = wLastCount;
        fork
            applyStimulus(32'h100, 1, 1'b0);
        join_none
        #1;
        checkOutput("lat_awvalid_before", bus.m_axi_awvalid, 0);
        checkOutput("lat_busy_before", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("lat_awvalid_after", bus.m_axi_awvalid, 1);
        checkOutput("lat_busy_after", busy, 1);
        checkOutput("lat_awaddr", bus.m_axi_awaddr, 32'h100);
        checkOutput("lat_awlen", bus.m_axi_awlen, 0);
        waitIdle("t1_idle_timeout");
        checkOutput("t1_handshakes", wHsCount - h0, 1);
        checkOutput("t1_wlasts", wLastCount - l0, 1);

        // 4-beat burst with toggling wready
        $display("[TB] 4-beat toggling wready");
        wreadyMode = 1;
        expectAw(32'h200, 8'd3);
        h0 = wHsCount;
        l0 = wLastCount;
        applyStimulus(32'h200, 4, 1'b0);
        waitIdle("t2_idle_timeout");
        checkOutput("t2_handshakes", wHsCount - h0, 4);
        checkOutput("t2_wlasts", wLastCount - l0, 1);
        wreadyMode = 0;

        // awready held off 5 cycles, valid gaps mid-burst
        $display("[TB] delayed awready");
        awDelay = 5;
        expectAw(32'h400, 8'd2);
        s0 = awStallCount;
        h0 = wHsCount;
        applyStimulus(32'h400, 3, 1'b1);
        waitIdle("t3_idle_timeout");
        checkOutput("t3_aw_stall_cycles", awStallCount - s0, 5);
        checkOutput("t3_handshakes", wHsCount - h0, 3);
        awDelay = 0;

        // 300-beat stream split into 256 + 44
        $display("[TB] 300-beat stream");
        expectAw(32'h2000, 8'd255);
        expectAw(32'h2400, 8'd43);
        h0 = wHsCount;
        l0 = wLastCount;
        applyStimulus(32'h2000, 300, 1'b0);
        waitIdle("t4_idle_timeout");
        checkOutput("t4_handshakes", wHsCount - h0, 300);
        checkOutput("t4_wlasts", wLastCount - l0, 2);
        checkOutput("t4_aw_left", expAwAddr.size(), 0);

        // SLVERR sets the sticky flag, next burst still completes
        $display("[TB] error handling");
        nextBresp = 2'b10;
        expectAw(32'h3000, 8'd1);
        applyStimulus(32'h3000, 2, 1'b0);
        waitIdle("t5a_idle_timeout");
        checkOutput("t5_error_set", error, 1);
        nextBresp = 2'b00;
        expectAw(32'h3100, 8'd1);
        h0 = wHsCount;
        applyStimulus(32'h3100, 2, 1'b0);
        waitIdle("t5b_idle_timeout");
        checkOutput("t5_error_sticky", error, 1);
        checkOutput("t5_next_burst_beats", wHsCount - h0, 2);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        checkOutput("t5_error_cleared", error, 0);

        // clear coinciding with a SLVERR handshake: set wins
        nextBresp = 2'b10;
        expectAw(32'h3200, 8'd0);
        fork
            applyStimulus(32'h3200, 1, 1'b0);
        join_none
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.m_axi_bready && c < 200);
        if (!bus.m_axi_bready) failNow("t5_bready_timeout");
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        nextBresp = 2'b00;
        @(negedge clk);
        checkOutput("t5_set_beats_clear", error, 1);
        waitIdle("t5c_idle_timeout");

        // Asynchronous reset in the middle of a 4-beat burst
        $display("[TB] reset mid-burst");
        expectAw(32'h6000, 8'd3);
        h0 = wHsCount;
        fork
            applyStimulus(32'h6000, 4, 1'b0);
        join_none
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while (wHsCount < h0 + 2 && c < 200);
        if (wHsCount < h0 + 2) failNow("t6_beats_timeout");
        rst_n = 1'b0;
        abortReq = 1'b1;
        #1;
        checkOutput("t6_awvalid", bus.m_axi_awvalid, 0);
        checkOutput("t6_wvalid", bus.m_axi_wvalid, 0);
        checkOutput("t6_wlast", bus.m_axi_wlast, 0);
        checkOutput("t6_bready", bus.m_axi_bready, 0);
        checkOutput("t6_dma_ready", bus.dma_w_ready, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_error", error, 0);
        checkOutput("t6_awaddr", bus.m_axi_awaddr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        abortReq = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_after_release", busy, 0);
        expectAw(32'h7000, 8'd1);
        h0 = wHsCount;
        l0 = wLastCount;
        applyStimulus(32'h7000, 2, 1'b0);
        waitIdle("t6_idle_timeout");
        checkOutput("t6_new_burst_beats", wHsCount - h0, 2);
        checkOutput("t6_new_burst_wlasts", wLastCount - l0, 1);

        // Nothing expected may be left unconsumed
        checkOutput("final_aw_left", expAwAddr.size(), 0);
        checkOutput("final_w_left", expWData.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
